uart_bus_master: RTL
====================

Name: uart_bus_master

Overview:
- Bus initiator that drives the register port of the uart_encode peripheral.
- Accepts one byte-level command (transmit a byte, or receive a byte) at a given baud divisor and expands it into the peripheral's register access sequence: baud register, mode register, then data register.
- Waits for the peripheral's ready, returns received data or a timeout status, then releases the bus.
- Sits between a CPU or DMA command source and one uart_encode instance; two instances can drive a pair of cross-connected UARTs.

Parameters:
- TIMEOUT_CYCLES, 4096, max access-phase cycles on the data register before abort (>=2).
- ADDR_DATA, 10'd0, word address of the data register.
- ADDR_MODE, 10'd2, word address of the mode register.
- ADDR_BAUD, 10'd4, word address of the baud divisor register.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command (high only in IDLE).
- cmd_rx  in  1  0 = transmit, 1 = receive.
- cmd_baud  in  32  baud divisor for this command.
- cmd_byte  in  8  byte to transmit (ignored when cmd_rx=1).
- rsp_valid  out  1  one-cycle pulse: command finished.
- rsp_byte  out  8  received byte (0 for transmit commands).
- rsp_timeout  out  1  qualifies rsp_valid: data access aborted.
- sel  out  1  peripheral select.
- enable  out  1  access-phase strobe.
- addr  out  10  register word address (addr[11:2] of peripheral).
- data_out  out  32  write data to peripheral.
- data_in  in  32  read data from peripheral.
- ready  in  1  peripheral completion.

Behaviour:
- Reset (rst=0, asynchronous):
  - sel=0, enable=0, addr=0, data_out=0.
  - rsp_valid=0, rsp_byte=0, rsp_timeout=0.
  - cmd_ready=0 during reset, 1 in the first cycle after reset is released.
  - cfg_valid cleared. State returns to IDLE.
- Mid-operation reset aborts immediately. No rsp_valid is produced.
- Command capture: a command is accepted on the rising edge where cmd_valid and cmd_ready are both 1. cmd_rx, cmd_baud and cmd_byte are registered at that edge; the inputs may change afterwards.
- States: IDLE, BAUD_SETUP, BAUD_ACCESS, BAUD_GAP, MODE_SETUP, MODE_ACCESS, MODE_GAP, DATA_SETUP, DATA_ACCESS, DONE.
- Setup phase: sel=1, enable=0, addr/data_out valid. Always exactly 1 cycle.
- Access phase: sel=1, enable=1, addr/data_out unchanged from the setup phase.
- Gap: sel=0, enable=0, addr=0, data_out=0. Exactly 1 cycle between accesses.
- Config accesses (baud, mode): access phase lasts exactly 1 cycle, regardless of ready.
- Baud stage: data_out=cmd_baud, addr=ADDR_BAUD. The stage is skipped (IDLE goes directly to MODE_SETUP) when cfg_valid=1 and the captured baud equals the last programmed baud.
- Mode stage: data_out=1 for transmit, 2 for receive; addr=ADDR_MODE. The stage is skipped under the same rule using the last programmed mode. When it is skipped, the preceding gap goes straight to DATA_SETUP.
- Shadow update: the baud and mode shadows, and cfg_valid, update at the end of each completed config access phase.
- Data stage: addr=ADDR_DATA; data_out={24'b0,cmd_byte} for transmit, 0 for receive.
- DATA_ACCESS exit conditions:
  - Held until ready=1 is sampled. On that edge, a receive command latches rsp_byte=data_in[7:0]; go to DONE.
  - If ready is not seen by the end of TIMEOUT_CYCLES access cycles, go to DONE with rsp_timeout=1. The timeout counter resets on entry to DATA_SETUP.
  - On timeout, also clear cfg_valid so the next command reprograms both registers.
- DONE:
  - 1 cycle, sel=0/enable=0.
  - rsp_valid=1 for this single cycle; rsp_byte/rsp_timeout hold until the next rsp_valid.
  - Next state IDLE; cmd_ready=1 the following cycle. Back-to-back commands are therefore separated by at least one idle bus cycle.
- Latency, accept edge to rsp_valid:
  - Full sequence, ready on first access cycle: BAUD(2) + gap + MODE(2) + gap + DATA_SETUP + 1 access = 8 cycles.
  - Both config stages skipped: 3 cycles.
- cmd_valid while busy: ignored (cmd_ready=0). There is no queueing.

Test Plan:
- Transmit, cold config: cmd_rx=0, cmd_baud=20, cmd_byte=101, peripheral model asserts ready 240 cycles into the access phase.
  - Bus sequence: addr 4 data 20 → gap → addr 2 data 1 → gap → addr 0 data 101.
  - enable held until ready; rsp_valid once, rsp_timeout=0, rsp_byte=0.
- Receive: cmd_rx=1, cmd_baud=40; model returns data_in=64 with ready.
  - Mode write data 2 is observed.
  - rsp_byte=64, rsp_timeout=0.
- Config skip: two transmit commands with baud=8 (bytes 35 then 36), ready given immediately.
  - Second command issues only DATA_SETUP/DATA_ACCESS; its latency is 3 cycles.
  - Changing baud to 18 on a third command re-issues the addr 4 write only.
- Timeout: TIMEOUT_CYCLES=16, ready tied 0.
  - enable high for exactly 16 cycles, then rsp_valid with rsp_timeout=1.
  - The next command with the same baud/mode still writes both config registers.
- Reset mid-access: assert rst low during DATA_ACCESS.
  - sel/enable drop to 0 asynchronously (before the next clock edge); no rsp_valid.
  - After release, cmd_ready=1 and the next command writes both config registers.
- Busy rejection: pulse cmd_valid with different data during MODE_ACCESS.
  - The command is not accepted; the current transaction completes with its original data.

Source files
------------

// File: rtl/uart_bus_master.sv
// Bus initiator for one uart_encode peripheral. Each command becomes up to three
// register writes/reads: baud, mode, then data. Config writes are skipped when unchanged.
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [9:0]  ADDR_DATA      = 10'd0,
  parameter logic [9:0]  ADDR_MODE      = 10'd2,
  parameter logic [9:0]  ADDR_BAUD      = 10'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rx,
  input  logic [31:0] cmd_baud,
  input  logic [7:0]  cmd_byte,
  output logic        rsp_valid,
  output logic [7:0]  rsp_byte,
  output logic        rsp_timeout,
  output logic        sel,
  output logic        enable,
  output logic [9:0]  addr,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  input  logic        ready
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    IDLE, BAUD_SETUP, BAUD_ACCESS, BAUD_GAP, MODE_SETUP,
    MODE_ACCESS, MODE_GAP, DATA_SETUP, DATA_ACCESS, DONE
  } state_e;

  state_e        state_q, state_d;
  logic          rx_q;
  logic [31:0]   baud_q;
  logic [7:0]    byte_q;
  logic          skip_mode_q;
  logic [31:0]   baud_sh_q;
  logic [1:0]    mode_sh_q;
  logic          cfg_valid_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    rsp_byte_q;
  logic          rsp_timeout_q;

  logic          accept;
  logic          tmo_last;
  logic [1:0]    cmd_mode;
  logic [1:0]    mode_val;
  logic [23:0]   unused_data_hi;

  // Gated with rst so no command can be taken while the block is held in reset.
  assign cmd_ready      = (state_q == IDLE) && rst;
  assign accept         = cmd_valid && cmd_ready;
  assign cmd_mode       = cmd_rx ? 2'd2 : 2'd1;
  assign mode_val       = rx_q ? 2'd2 : 2'd1;
  assign tmo_last       = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_byte       = rsp_byte_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign unused_data_hi = data_in[31:8];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    sel       = 1'b0;
    enable    = 1'b0;
    addr      = '0;
    data_out  = '0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!(cfg_valid_q && cmd_baud == baud_sh_q))     state_d = BAUD_SETUP;
          else if (!(cfg_valid_q && cmd_mode == mode_sh_q)) state_d = MODE_SETUP;
          // Both registers current: spend one idle bus cycle, then go to the data access.
          else                                              state_d = MODE_GAP;
        end
      end
      BAUD_SETUP, BAUD_ACCESS: begin
        sel      = 1'b1;
        enable   = (state_q == BAUD_ACCESS);
        addr     = ADDR_BAUD;
        data_out = baud_q;
        state_d  = (state_q == BAUD_SETUP) ? BAUD_ACCESS : BAUD_GAP;
      end
      BAUD_GAP: state_d = skip_mode_q ? DATA_SETUP : MODE_SETUP;
      MODE_SETUP, MODE_ACCESS: begin
        sel      = 1'b1;
        enable   = (state_q == MODE_ACCESS);
        addr     = ADDR_MODE;
        data_out = {30'b0, mode_val};
        state_d  = (state_q == MODE_SETUP) ? MODE_ACCESS : MODE_GAP;
      end
      MODE_GAP: state_d = DATA_SETUP;
      DATA_SETUP, DATA_ACCESS: begin
        sel      = 1'b1;
        enable   = (state_q == DATA_ACCESS);
        addr     = ADDR_DATA;
        data_out = rx_q ? 32'b0 : {24'b0, byte_q};
        if (state_q == DATA_SETUP)  state_d = DATA_ACCESS;
        else if (ready || tmo_last) state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rx_q          <= 1'b0;
      baud_q        <= '0;
      byte_q        <= '0;
      skip_mode_q   <= 1'b0;
      baud_sh_q     <= '0;
      mode_sh_q     <= '0;
      cfg_valid_q   <= 1'b0;
      tmo_q         <= '0;
      rsp_byte_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            rx_q        <= cmd_rx;
            baud_q      <= cmd_baud;
            byte_q      <= cmd_byte;
            // Decided at accept time so a shadow refreshed by the baud write cannot mask a stale mode.
            skip_mode_q <= cfg_valid_q && (cmd_mode == mode_sh_q);
          end
        end
        BAUD_ACCESS: begin
          baud_sh_q   <= baud_q;
          cfg_valid_q <= 1'b1;
        end
        MODE_ACCESS: begin
          mode_sh_q   <= mode_val;
          cfg_valid_q <= 1'b1;
        end
        DATA_SETUP: tmo_q <= '0;
        DATA_ACCESS: begin
          tmo_q <= tmo_q + 1'b1;
          if (ready) begin
            rsp_byte_q    <= rx_q ? data_in[7:0] : 8'd0;
            rsp_timeout_q <= 1'b0;
          end else if (tmo_last) begin
            rsp_byte_q    <= 8'd0;
            rsp_timeout_q <= 1'b1;
            cfg_valid_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
